// File: rtl/mmac_stream_engine.sv
`default_nettype none
// ============================================================================
// Module   : mmac_stream_engine
// Brief    : Streaming N x N matrix multiply (C = A x B) built around a single
//            sequential MAC, with signed/unsigned and saturate/wrap modes.
// Revision : 1.0 - initial release
// ============================================================================
module mmac_stream_engine #(
   parameter int M_SIZE     = 4,
   parameter int VAR_WIDTH  = 8,
   parameter int DATA_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [VAR_WIDTH-1:0]  in_data,
   input  logic                  signed_mode,
   input  logic                  sat_en,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_last,
   output logic                  busy,
   output logic                  done
);
   localparam int NN     = M_SIZE * M_SIZE;
   localparam int LD_W   = $clog2(2 * NN);
   localparam int IDX_W  = $clog2(M_SIZE);
   localparam int PROD_W = 2 * VAR_WIDTH;
   localparam int ACC_W  = PROD_W + $clog2(M_SIZE) + 1;
   localparam int EXT_W  = ((ACC_W > DATA_WIDTH) ? ACC_W : DATA_WIDTH) + 2;

   localparam logic [LD_W-1:0]         c_last_beat = LD_W'(2 * NN - 1);
   localparam logic [IDX_W-1:0]        c_last_idx  = IDX_W'(M_SIZE - 1);
   localparam logic signed [EXT_W-1:0] c_smax = {{(EXT_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
   localparam logic signed [EXT_W-1:0] c_smin = {{(EXT_W-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};
   localparam logic signed [EXT_W-1:0] c_umax = {{(EXT_W-DATA_WIDTH){1'b0}}, {DATA_WIDTH{1'b1}}};

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_MAC  = 2'd2,
      S_OUT  = 2'd3
   } state_t;

   state_t                  r_state;
   logic [LD_W-1:0]         r_ld_cnt;
   logic [IDX_W-1:0]        r_i, r_j, r_k;
   logic [ACC_W-1:0]        r_acc;
   logic                    r_signed, r_sat;
   logic                    r_in_ready, r_out_valid, r_out_last, r_busy, r_done;
   logic [DATA_WIDTH-1:0]   r_out_data;
   logic [VAR_WIDTH-1:0]    r_mem [2*NN];

   logic                    w_in_hs;
   logic [LD_W-1:0]         w_wr_idx, w_a_idx, w_b_idx;
   logic [VAR_WIDTH-1:0]    w_a, w_b;
   logic [PROD_W-1:0]       w_a_ext, w_b_ext, w_prod;
   logic [ACC_W-1:0]        w_prod_ext, w_acc_sum;
   logic signed [EXT_W-1:0] w_acc_wide;
   logic [DATA_WIDTH-1:0]   w_result;

   assign w_in_hs  = in_valid & r_in_ready;
   assign w_wr_idx = (r_state == S_IDLE) ? '0 : r_ld_cnt;

   // Operand store: A occupies entries [0, NN), B occupies [NN, 2*NN), row-major.
   always_ff @(posedge clk) begin
      if (w_in_hs) begin
         r_mem[w_wr_idx] <= in_data;
      end
   end

   assign w_a_idx = LD_W'(int'(r_i) * M_SIZE + int'(r_k));
   assign w_b_idx = LD_W'(NN + int'(r_k) * M_SIZE + int'(r_j));
   assign w_a     = r_mem[w_a_idx];
   assign w_b     = r_mem[w_b_idx];

   // Low PROD_W bits of the product are identical for signed and unsigned once operands are extended.
   assign w_a_ext    = r_signed ? {{VAR_WIDTH{w_a[VAR_WIDTH-1]}}, w_a} : {{VAR_WIDTH{1'b0}}, w_a};
   assign w_b_ext    = r_signed ? {{VAR_WIDTH{w_b[VAR_WIDTH-1]}}, w_b} : {{VAR_WIDTH{1'b0}}, w_b};
   assign w_prod     = w_a_ext * w_b_ext;
   assign w_prod_ext = r_signed ? {{(ACC_W-PROD_W){w_prod[PROD_W-1]}}, w_prod}
                                : {{(ACC_W-PROD_W){1'b0}}, w_prod};
   assign w_acc_sum  = r_acc + w_prod_ext;
   assign w_acc_wide = r_signed ? {{(EXT_W-ACC_W){w_acc_sum[ACC_W-1]}}, w_acc_sum}
                                : {{(EXT_W-ACC_W){1'b0}}, w_acc_sum};

   always_comb begin
      w_result = w_acc_wide[DATA_WIDTH-1:0];
      if (r_sat) begin
         if (r_signed) begin
            if (w_acc_wide > c_smax) begin
               w_result = c_smax[DATA_WIDTH-1:0];
            end else if (w_acc_wide < c_smin) begin
               w_result = c_smin[DATA_WIDTH-1:0];
            end
         end else if (w_acc_wide > c_umax) begin
            w_result = c_umax[DATA_WIDTH-1:0];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_ld_cnt    <= '0;
         r_i         <= '0;
         r_j         <= '0;
         r_k         <= '0;
         r_acc       <= '0;
         r_signed    <= 1'b0;
         r_sat       <= 1'b0;
         r_in_ready  <= 1'b0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_last  <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               r_in_ready <= 1'b1;
               if (w_in_hs) begin
                  r_signed <= signed_mode;
                  r_sat    <= sat_en;
                  r_ld_cnt <= LD_W'(1);
                  r_busy   <= 1'b1;
                  r_state  <= S_LOAD;
               end
            end
            S_LOAD: begin
               if (w_in_hs) begin
                  r_ld_cnt <= r_ld_cnt + 1'b1;
                  if (r_ld_cnt == c_last_beat) begin
                     r_in_ready <= 1'b0;
                     r_acc      <= '0;
                     r_i        <= '0;
                     r_j        <= '0;
                     r_k        <= '0;
                     r_state    <= S_MAC;
                  end
               end
            end
            S_MAC: begin
               r_acc <= w_acc_sum;
               r_k   <= r_k + 1'b1;
               if (r_k == c_last_idx) begin
                  r_k         <= '0;
                  r_out_valid <= 1'b1;
                  r_out_data  <= w_result;
                  r_out_last  <= (r_i == c_last_idx) && (r_j == c_last_idx);
                  r_state     <= S_OUT;
               end
            end
            S_OUT: begin
               if (r_out_valid && out_ready) begin
                  r_out_valid <= 1'b0;
                  r_out_last  <= 1'b0;
                  r_acc       <= '0;
                  if (r_out_last) begin
                     r_busy     <= 1'b0;
                     r_done     <= 1'b1;
                     r_in_ready <= 1'b1;
                     r_state    <= S_IDLE;
                  end else begin
                     if (r_j == c_last_idx) begin
                        r_j <= '0;
                        r_i <= r_i + 1'b1;
                     end else begin
                        r_j <= r_j + 1'b1;
                     end
                     r_state <= S_MAC;
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign out_last  = r_out_last;
   assign busy      = r_busy;
   assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_mmac_stream_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_mmac_stream_engine
// Brief    : Directed, table-driven bench for mmac_stream_engine (N=4, 8b in, 16b out).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mmac_stream_engine;
   localparam int N  = 4;
   localparam int NO = N * N;
   localparam int NB = 2 * NO;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [7:0]  in_data = 8'h00;
   logic        signed_mode = 1'b0;
   logic        sat_en = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [15:0] out_data;
   logic        out_last;
   logic        busy;
   logic        done;

   int n_cmp = 0;
   int n_bad = 0;
   int cycle_cnt = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

   mmac_stream_engine #(.M_SIZE(N), .VAR_WIDTH(8), .DATA_WIDTH(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .signed_mode(signed_mode), .sat_en(sat_en),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_last(out_last), .busy(busy), .done(done)
   );

   typedef struct {
      int          kind;    // 0 = identity A, B[r][c]=4r+c; 1 = constant-filled A and B
      logic [7:0]  a;
      logic [7:0]  b;
      logic        sm;
      logic        sat;
      logic [15:0] exp_c;
      int          gap;
      int          stall;
   } vec_t;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, want, $time);
      end
   endtask

   task automatic run_job(input int kind, input logic [7:0] av, input logic [7:0] bv,
                          input logic sm, input logic sat, input logic [15:0] exp_c,
                          input int gap, input int stall, input int abort_at);
      logic [7:0]  beats [NB];
      logic [15:0] held, exp_v;
      bit          have_hold, seen;
      int          idx, k, cyc, prev, since;
      exp_v = '0;
      for (int r = 0; r < N; r++) begin
         for (int c = 0; c < N; c++) begin
            if (kind == 0) begin
               beats[r*N+c]    = (r == c) ? 8'd1 : 8'd0;
               beats[NO+r*N+c] = 8'(N*r + c);
            end else begin
               beats[r*N+c]    = av;
               beats[NO+r*N+c] = bv;
            end
         end
      end
      // Modes are inverted after the first beat; the engine must ignore that.
      idx = 0;
      cyc = 0;
      while (idx < NB && cyc < 2000) begin
         @(negedge clk);
         cyc++;
         if (idx > 0 && gap > 0 && $urandom_range(0, 99) < gap) begin
            in_valid = 1'b0;
         end else begin
            in_valid    = 1'b1;
            in_data     = beats[idx];
            signed_mode = (idx == 0) ? sm : ~sm;
            sat_en      = (idx == 0) ? sat : ~sat;
         end
         if (in_valid && in_ready) idx++;
      end
      if (idx < NB) begin
         check("input_timeout", idx, NB);
         in_valid = 1'b0;
         return;
      end
      prev      = cycle_cnt + 1;
      k         = 0;
      cyc       = 0;
      seen      = 0;
      have_hold = 0;
      since     = 0;
      while (k < NO && cyc < 4000) begin
         @(negedge clk);
         cyc++;
         in_valid = 1'b0;
         if (abort_at >= 0 && k == abort_at) begin
            since++;
            if (since == 2) begin
               rst_n = 1'b0;
               #1;
               check("abort_out_valid", out_valid, 0);
               check("abort_out_data", out_data, 0);
               check("abort_out_last", out_last, 0);
               check("abort_busy", busy, 0);
               check("abort_in_ready", in_ready, 0);
               check("abort_done", done, 0);
               return;
            end
            continue;
         end
         out_ready = (stall > 0 && $urandom_range(0, 99) < stall) ? 1'b0 : 1'b1;
         if (out_valid) begin
            if (!seen) begin
               seen = 1;
               check("valid_spacing", cycle_cnt - prev, N);
            end
            if (have_hold) check("stall_hold", out_data, held);
            if (out_ready) begin
               exp_v = (kind == 0) ? 16'(k) : exp_c;
               check("data", out_data, exp_v);
               check("last", out_last, (k == NO - 1) ? 1 : 0);
               prev      = cycle_cnt + 1;
               k++;
               seen      = 0;
               have_hold = 0;
            end else begin
               held      = out_data;
               have_hold = 1;
            end
         end
      end
      if (k < NO) begin
         check("output_timeout", k, NO);
         return;
      end
      @(negedge clk);
      out_ready = 1'b0;
      check("done_pulse", done, 1);
      check("busy_idle", busy, 0);
      check("in_ready_idle", in_ready, 1);
      check("out_valid_idle", out_valid, 0);
      check("out_last_idle", out_last, 0);
      check("out_data_hold", out_data, exp_v);
      @(negedge clk);
      check("done_once", done, 0);
   endtask

   initial begin
      vec_t tbl [12];
      tbl[0]  = '{0, 8'h00, 8'h00, 1'b1, 1'b0, 16'h0000, 0,  0};
      tbl[1]  = '{1, 8'h7F, 8'h7F, 1'b1, 1'b1, 16'h7FFF, 0,  0};
      tbl[2]  = '{1, 8'h7F, 8'h7F, 1'b1, 1'b0, 16'hFC04, 0,  0};
      tbl[3]  = '{1, 8'h80, 8'h7F, 1'b1, 1'b1, 16'h8000, 0,  0};
      tbl[4]  = '{1, 8'h80, 8'h7F, 1'b1, 1'b0, 16'h0200, 0,  0};
      tbl[5]  = '{1, 8'hFF, 8'hFF, 1'b0, 1'b1, 16'hFFFF, 0,  0};
      tbl[6]  = '{1, 8'hFF, 8'hFF, 1'b0, 1'b0, 16'hF804, 0,  0};
      tbl[7]  = '{1, 8'hFD, 8'h05, 1'b1, 1'b1, 16'hFFC4, 0,  0};
      tbl[8]  = '{1, 8'h80, 8'h80, 1'b0, 1'b1, 16'hFFFF, 0,  0};
      tbl[9]  = '{1, 8'h80, 8'h80, 1'b1, 1'b1, 16'h7FFF, 0,  0};
      tbl[10] = '{0, 8'h00, 8'h00, 1'b1, 1'b0, 16'h0000, 40, 40};
      tbl[11] = '{1, 8'h7F, 8'h7F, 1'b1, 1'b1, 16'h7FFF, 30, 50};

      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_in_ready", in_ready, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_out_last", out_last, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      rst_n = 1'b1;
      @(negedge clk);

      for (int t = 0; t < 12; t++) begin
         run_job(tbl[t].kind, tbl[t].a, tbl[t].b, tbl[t].sm, tbl[t].sat,
                 tbl[t].exp_c, tbl[t].gap, tbl[t].stall, -1);
      end

      // Abort during the third element's MAC, then a clean identity job.
      run_job(0, 8'h00, 8'h00, 1'b1, 1'b0, 16'h0000, 0, 0, 2);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      run_job(0, 8'h00, 8'h00, 1'b1, 1'b0, 16'h0000, 0, 0, -1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
